// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: funct3 size codes, FSM states, lane helpers.
// Byte-lane helpers are shared so store packing and alignment checks agree on size decoding.
package mem_stage_pkg;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Access size lives in funct3[1:0]; the sign bit does not affect alignment or lanes.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] m;
    case (f3[1:0])
      2'b00:   m = {24'h0, d[7:0]};
      2'b01:   m = {16'h0, d[15:0]};
      default: m = d;
    endcase
    return m << {a, 3'b000};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/halfword of a read word and sign/zero-extends it.
// Purely combinational, no handshake.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [15:0] lane;

  assign lane = 16'(word_i >> {off_i, 3'b000});

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'h0, lane[7:0]};
      F3_HU:   data_o = {16'h0, lane};
      F3_W:    data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: ALU results pass through with zero latency; loads/stores run IDLE->REQ->DONE.
// stall_req holds upstream from op acceptance until DONE (or bus error / misalign release).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] st_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;

  logic        mem_op;
  logic        bad_align;
  logic [31:0] load_fmt;

  // Gating with rst keeps the stage in pure pass-through while held in reset.
  assign mem_op    = rst & (mem_rd_i | mem_wr_i);
  assign bad_align = is_misaligned(funct3_i, alu_res_i[1:0]);

  load_align u_load_align (
    .word_i   (dm_rdata),
    .off_i    (alu_res_i[1:0]),
    .funct3_i (funct3_i),
    .data_o   (load_fmt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      load_buf_q <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_buf_q <= load_buf_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_be_q    <= dm_be_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_buf_d = load_buf_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_be_d    = dm_be_q;
    rd_we      = 1'b0;
    rd_addr    = rd_addr_i;
    rd_data    = alu_res_i;
    stall_req  = 1'b0;
    misalign   = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!mem_op) begin
          rd_we = rd_we_i;
        end else if (bad_align) begin
          misalign = 1'b1;
        end else begin
          stall_req  = 1'b1;
          dm_req_d   = 1'b1;
          dm_we_d    = mem_wr_i;
          dm_addr_d  = {alu_res_i[31:2], 2'b00};
          dm_be_d    = byte_mask(funct3_i, alu_res_i[1:0]);
          dm_wdata_d = store_lanes(funct3_i, alu_res_i[1:0], st_data_i);
          state_d    = REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (dm_ack) begin
          if (!dm_we_q) load_buf_d = load_fmt;
          dm_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err   = 1'b1;
          stall_req = 1'b0;
          dm_req_d  = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!dm_we_q) begin
          rd_we   = rd_we_i;
          rd_data = load_buf_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_be    = dm_be_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: default-TIMEOUT instance plus a TIMEOUT=4 instance on shared inputs.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] alu_res_i;
  logic [31:0] st_data_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        dm_req, dm_we, rd_we, stall_req, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, rd_data;
  logic [3:0]  dm_be;
  logic [4:0]  rd_addr;

  logic        t_dm_req, t_dm_we, t_rd_we, t_stall_req, t_misalign, t_bus_err;
  logic [31:0] t_dm_addr, t_dm_wdata, t_rd_data;
  logic [3:0]  t_dm_be;
  logic [4:0]  t_rd_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0]  LF_F3    [3] = '{3'b001, 3'b100, 3'b010};
  localparam logic [31:0] LF_ADDR  [3] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0004};
  localparam logic [31:0] LF_RDATA [3] = '{32'h8001_0000, 32'h0000_9A00, 32'hCAFE_F00D};
  localparam logic [31:0] LF_EXP   [3] = '{32'hFFFF_8001, 32'h0000_009A, 32'hCAFE_F00D};

  mem_stage dut (
    .clk(clk), .rst(rst), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .alu_res_i(alu_res_i),
    .st_data_i(st_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .funct3_i(funct3_i),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .stall_req(stall_req), .misalign(misalign), .bus_err(bus_err)
  );

  mem_stage #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .alu_res_i(alu_res_i),
    .st_data_i(st_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .funct3_i(funct3_i),
    .dm_req(t_dm_req), .dm_we(t_dm_we), .dm_addr(t_dm_addr), .dm_wdata(t_dm_wdata), .dm_be(t_dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .rd_we(t_rd_we), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
    .stall_req(t_stall_req), .misalign(t_misalign), .bus_err(t_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic we, input logic [4:0] ra);
    mem_rd_i  = rd;
    mem_wr_i  = wr;
    funct3_i  = f3;
    alu_res_i = addr;
    st_data_i = sd;
    rd_we_i   = we;
    rd_addr_i = ra;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 5'd7);
    #1;
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL rst_rd_we: got %b want 1", rd_we); end
    checks++; if (rd_addr !== 5'd7) begin errors++; $display("FAIL rst_rd_addr: got %0d want 7", rd_addr); end
    checks++; if (rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rst_rd_data: got %h want 12345678", rd_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_req); end
    checks++; if ({dm_req, dm_we, dm_be} !== 6'b0) begin errors++; $display("FAIL rst_dm_ctl: got %b want 0", {dm_req, dm_we, dm_be}); end
    checks++; if ({dm_addr, dm_wdata} !== 64'h0) begin errors++; $display("FAIL rst_dm_bus: got %h want 0", {dm_addr, dm_wdata}); end
    checks++; if ({misalign, bus_err} !== 2'b00) begin errors++; $display("FAIL rst_exc: got %b want 00", {misalign, bus_err}); end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b1, 5'd8);
    #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign_gate: got %b want 0", misalign); end
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL rst_mem_passthru: got %b want 1", rd_we); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    rst = 1'b1;
    drive_op(1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd3);
    #1;
    checks++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin errors++; $display("FAIL pass_a: got %b %0d %h want 1 3 deadbeef", rd_we, rd_addr, rd_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL pass_a_stall: got %b want 0", stall_req); end
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 1'b0, 5'd31);
    #1;
    checks++; if ({rd_we, rd_addr, rd_data} !== {1'b0, 5'd31, 32'h0000_0042}) begin errors++; $display("FAIL pass_b: got %b %0d %h want 0 31 42", rd_we, rd_addr, rd_data); end
  endtask

  task automatic test_lb();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1, 5'd9);
    #1;
    checks++; if ({stall_req, rd_we, dm_req} !== 3'b100) begin errors++; $display("FAIL lb_idle: got %b want 100", {stall_req, rd_we, dm_req}); end
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'h80FF_1234;
    #1;
    checks++; if ({dm_req, dm_we, stall_req, rd_we} !== 4'b1010) begin errors++; $display("FAIL lb_req: got %b want 1010", {dm_req, dm_we, stall_req, rd_we}); end
    checks++; if (dm_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr: got %h want 00000100", dm_addr); end
    @(negedge clk);
    dm_ack = 1'b0; dm_rdata = 32'h1111_1111;
    #1;
    checks++; if (rd_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rd_data); end
    checks++; if ({rd_we, rd_addr, stall_req, dm_req} !== {1'b1, 5'd9, 2'b00}) begin errors++; $display("FAIL lb_done: got %b %0d %b %b want 1 9 0 0", rd_we, rd_addr, stall_req, dm_req); end
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lb_after: got %b want 0", stall_req); end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 1'b1, 5'd5);
    @(negedge clk);
    dm_ack = 1'b1;
    #1;
    checks++; if (dm_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", dm_be); end
    checks++; if (dm_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata: got %h want abcd0000", dm_wdata); end
    checks++; if ({dm_req, dm_we, dm_addr} !== {2'b11, 32'h0000_0100}) begin errors++; $display("FAIL sh_req: got %b %b %h want 1 1 00000100", dm_req, dm_we, dm_addr); end
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    checks++; if ({rd_we, stall_req} !== 2'b00) begin errors++; $display("FAIL sh_done: got %b want 00", {rd_we, stall_req}); end
    // both strobes high must behave as a store
    @(negedge clk);
    drive_op(1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 1'b1, 5'd6);
    @(negedge clk);
    dm_ack = 1'b1;
    #1;
    checks++; if ({dm_we, dm_be, dm_wdata} !== {1'b1, 4'b0010, 32'h0000_A500}) begin errors++; $display("FAIL sb_both: got %b %b %h want 1 0010 0000a500", dm_we, dm_be, dm_wdata); end
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL sb_both_done: got %b want 0", rd_we); end
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b1, 5'd4);
    #1;
    checks++; if ({misalign, stall_req, rd_we, dm_req} !== 4'b1000) begin errors++; $display("FAIL lw_mis: got %b want 1000", {misalign, stall_req, rd_we, dm_req}); end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0005, 32'h0, 1'b1, 5'd4);
    #1;
    checks++; if ({misalign, dm_req, stall_req} !== 3'b100) begin errors++; $display("FAIL lh_mis: got %b want 100", {misalign, dm_req, stall_req}); end
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 1'b1, 5'd2);
    #1;
    checks++; if ({misalign, dm_req, rd_we, rd_data} !== {3'b001, 32'h0000_0077}) begin errors++; $display("FAIL mis_after: got %b %b %b %h want 0 0 1 77", misalign, dm_req, rd_we, rd_data); end
  endtask

  task automatic test_lhu_wait();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 1'b1, 5'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({dm_req, dm_we, dm_addr, dm_be, stall_req} !== {2'b10, 32'h0000_0010, 4'b0011, 1'b1}) begin errors++; $display("FAIL lhu_wait%0d: got %b %b %h %b %b", i, dm_req, dm_we, dm_addr, dm_be, stall_req); end
    end
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'h0000_F00D;
    #1;
    checks++; if ({dm_req, stall_req, rd_we} !== 3'b110) begin errors++; $display("FAIL lhu_ack: got %b want 110", {dm_req, stall_req, rd_we}); end
    @(negedge clk);
    dm_ack = 1'b0; dm_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd12, 32'h0000_F00D}) begin errors++; $display("FAIL lhu_done: got %b %0d %h want 1 12 0000f00d", rd_we, rd_addr, rd_data); end
    @(negedge clk);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_load_format();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_op(1'b1, 1'b0, LF_F3[k], LF_ADDR[k], 32'h0, 1'b1, 5'd1);
      @(negedge clk);
      dm_ack = 1'b1; dm_rdata = LF_RDATA[k];
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      checks++; if (rd_data !== LF_EXP[k]) begin errors++; $display("FAIL ldfmt%0d: got %h want %h", k, rd_data, LF_EXP[k]); end
      @(negedge clk);
      drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b1, 5'd2);
    #1;
    checks++; if (t_stall_req !== 1'b1) begin errors++; $display("FAIL to_issue: got %b want 1", t_stall_req); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({t_dm_req, t_bus_err, t_stall_req} !== 3'b101) begin errors++; $display("FAIL to_wait%0d: got %b want 101", i, {t_dm_req, t_bus_err, t_stall_req}); end
    end
    @(negedge clk);
    #1;
    checks++; if ({t_bus_err, t_stall_req, t_rd_we} !== 3'b100) begin errors++; $display("FAIL to_err: got %b want 100", {t_bus_err, t_stall_req, t_rd_we}); end
    @(negedge clk);
    #1;
    checks++; if ({t_bus_err, t_dm_req} !== 2'b00) begin errors++; $display("FAIL to_after: got %b want 00", {t_bus_err, t_dm_req}); end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    #1;
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", dm_req); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({dm_req, stall_req, dm_addr} !== {2'b00, 32'h0}) begin errors++; $display("FAIL mid_rst: got %b %b %h want 0 0 0", dm_req, stall_req, dm_addr); end
    checks++; if ({rd_we, rd_data} !== {1'b1, 32'h0000_0020}) begin errors++; $display("FAIL mid_rst_pass: got %b %h want 1 00000020", rd_we, rd_data); end
    @(negedge clk);
    rst = 1'b1;
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1, 5'd4);
    #1;
    checks++; if ({rd_we, rd_addr, rd_data, stall_req, dm_req} !== {1'b1, 5'd4, 32'h0000_0055, 2'b00}) begin errors++; $display("FAIL rel_pass: got %b %0d %h %b %b", rd_we, rd_addr, rd_data, stall_req, dm_req); end
    @(negedge clk);
    #1;
    checks++; if ({dm_req, rd_data} !== {1'b0, 32'h0000_0055}) begin errors++; $display("FAIL rel_next: got %b %h want 0 00000055", dm_req, rd_data); end
  endtask

  initial begin
    rst = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    test_reset();
    test_passthrough();
    test_lb();
    test_store();
    test_misalign();
    test_lhu_wait();
    test_load_format();
    test_timeout();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
